// File: rtl/series_sum_display.sv
// series_sum_display
//   Series-sum engine with a 7-segment readout. A rising edge on start latches
//   n_in and mode. The block then accumulates sum(i) or sum(i^2) for i=1..N,
//   adding one term per clklento cycle. It converts the result to BCD by serial
//   double-dabble and shows it on DIGITS active-low 7-segment digits.
//
//   Ports:
//     clklento  in   slow system clock, rising edge
//     rst       in   asynchronous, active-high reset
//     n_in      in   series upper bound N (N_W bits)
//     mode      in   0: sum of i, 1: sum of i^2
//     start     in   run request level; only its rising edge is used
//     busy      out  accumulating or converting
//     done      out  hex_out holds a valid result
//     overflow  out  result exceeded ACC_W bits or the displayable range
//     hex_out   out  digit k at [7k+6:7k], bit 7k+6 = seg a .. bit 7k = seg g,
//                    active low
module series_sum_display #(
    parameter int N_W    = 5,
    parameter int ACC_W  = 14,
    parameter int DIGITS = 5
) (
    input  logic                  clklento,
    input  logic                  rst,
    input  logic [N_W-1:0]        n_in,
    input  logic                  mode,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int DD_W   = BCD_W + ACC_W;
    localparam int TERM_W = 2 * N_W;
    localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;
    localparam int SC_W   = $clog2(ACC_W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned DISP_MAX = pow10(DIGITS) - 1;

    // Active-low segment pattern, bit 6 = a .. bit 0 = g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q, start_d;
    logic [N_W-1:0]       n_lat_q, n_lat_d;
    logic                 mode_lat_q, mode_lat_d;
    logic [N_W-1:0]       count_q, count_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 ovf_int_q, ovf_int_d;
    logic [DD_W-1:0]      dd_q, dd_d;
    logic [SC_W-1:0]      shift_cnt_q, shift_cnt_d;
    logic [7*DIGITS-1:0]  hex_q, hex_d;
    logic                 overflow_q, overflow_d;

    logic                 start_rise;
    logic [N_W-1:0]       k;
    logic [TERM_W-1:0]    k_ext;
    logic [TERM_W-1:0]    term;
    logic [SUM_W-1:0]     sum_ext;
    logic [DD_W-1:0]      dd_adj;
    logic                 ovf_now;
    logic [7*DIGITS-1:0]  hex_next;
    logic                 lead;
    logic [3:0]           nib;

    // Next term k = count+1; k*k always fits in 2*N_W bits.
    always_comb begin
        k       = count_q + 1'b1;
        k_ext   = TERM_W'(k);
        term    = mode_lat_q ? (k_ext * k_ext) : k_ext;
        sum_ext = SUM_W'(acc_q) + SUM_W'(term);
    end

    // Double-dabble correction: add 3 to every BCD nibble >= 5 before shifting.
    always_comb begin
        dd_adj = dd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dd_q[ACC_W + 4*i +: 4] >= 4'd5)
                dd_adj[ACC_W + 4*i +: 4] = dd_q[ACC_W + 4*i +: 4] + 4'd3;
        end
    end

    assign ovf_now = ovf_int_q | (64'(acc_q) > DISP_MAX);

    // Display image for the finished conversion. Scans from the most
    // significant digit down and blanks zeros until the first non-zero digit.
    // Digit 0 is never blanked.
    always_comb begin
        hex_next = '1;
        lead     = 1'b1;
        nib      = '0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            nib = dd_q[ACC_W + 4*(DIGITS-1-j) +: 4];
            if (ovf_now) begin
                hex_next[7*(DIGITS-1-j) +: 7] = SEG_DASH;
            end else if (lead && (nib == 4'd0) && (j != DIGITS-1)) begin
                hex_next[7*(DIGITS-1-j) +: 7] = SEG_BLANK;
            end else begin
                lead = 1'b0;
                hex_next[7*(DIGITS-1-j) +: 7] = seg7(nib);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start;
        n_lat_d     = n_lat_q;
        mode_lat_d  = mode_lat_q;
        count_d     = count_q;
        acc_d       = acc_q;
        ovf_int_d   = ovf_int_q;
        dd_d        = dd_q;
        shift_cnt_d = shift_cnt_q;
        hex_d       = hex_q;
        overflow_d  = overflow_q;
        start_rise  = start & ~start_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    n_lat_d    = n_in;
                    mode_lat_d = mode;
                    count_d    = '0;
                    acc_d      = '0;
                    ovf_int_d  = 1'b0;
                    state_d    = S_SUM;
                end
            end
            S_SUM: begin
                if (count_q == n_lat_q) begin
                    dd_d        = {{BCD_W{1'b0}}, acc_q};
                    shift_cnt_d = '0;
                    state_d     = S_CONVERT;
                end else begin
                    count_d = count_q + 1'b1;
                    acc_d   = sum_ext[ACC_W-1:0];
                    if (|sum_ext[SUM_W-1:ACC_W]) ovf_int_d = 1'b1;
                end
            end
            S_CONVERT: begin
                // ACC_W shift cycles, then one more cycle to publish the result
                // from the fully shifted register.
                if (shift_cnt_q == SC_W'(ACC_W)) begin
                    hex_d      = hex_next;
                    overflow_d = ovf_now;
                    state_d    = S_DONE;
                end else begin
                    dd_d        = {dd_adj[DD_W-2:0], 1'b0};
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clklento or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            n_lat_q     <= '0;
            mode_lat_q  <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
            ovf_int_q   <= 1'b0;
            dd_q        <= '0;
            shift_cnt_q <= '0;
            hex_q       <= '1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            n_lat_q     <= n_lat_d;
            mode_lat_q  <= mode_lat_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            ovf_int_q   <= ovf_int_d;
            dd_q        <= dd_d;
            shift_cnt_q <= shift_cnt_d;
            hex_q       <= hex_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy     = (state_q == S_SUM) || (state_q == S_CONVERT);
    assign done     = (state_q == S_DONE);
    assign overflow = overflow_q;
    assign hex_out  = hex_q;

endmodule

// File: tb/tb_series_sum_display.sv
module tb_series_sum_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  n_in = '0;
    logic        mode = 1'b0;
    logic        start = 1'b0;

    logic        busy0, done0, ovf0;
    logic [34:0] hex0;
    logic        busy1, done1, ovf1;
    logic [34:0] hex1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    series_sum_display #(.N_W(5), .ACC_W(14), .DIGITS(5)) dut (
        .clklento(clk), .rst(rst), .n_in(n_in), .mode(mode), .start(start),
        .busy(busy0), .done(done0), .overflow(ovf0), .hex_out(hex0)
    );

    series_sum_display #(.N_W(5), .ACC_W(9), .DIGITS(5)) dut_narrow (
        .clklento(clk), .rst(rst), .n_in(n_in), .mode(mode), .start(start),
        .busy(busy1), .done(done1), .overflow(ovf1), .hex_out(hex1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    int          accw_m [2] = '{14, 9};
    bit          m_run  [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    bit          m_ovf  [2] = '{0, 0};
    int          m_t    [2] = '{0, 0};
    int          m_n    [2] = '{0, 0};
    bit          m_mode [2] = '{0, 0};
    logic [34:0] m_hex  [2] = '{'1, '1};
    bit          m_prev = 1'b0;

    function automatic int series(input int n, input bit sq);
        int s = 0;
        for (int i = 1; i <= n; i++) s += sq ? i * i : i;
        return s;
    endfunction

    function automatic logic [34:0] exp_hex(input int s, input bit ovf);
        logic [34:0] r = '1;
        int v = s;
        int k = 0;
        if (ovf) begin
            for (int j = 0; j < 5; j++) r[7*j +: 7] = 7'b1111110;
        end else begin
            do begin
                r[7*k +: 7] = seg_tab[v % 10];
                v = v / 10;
                k++;
            end while (v > 0 && k < 5);
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit rise;
        int s;
        bit o;
        if (rst) begin
            m_prev = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_run[d] = 0; m_done[d] = 0; m_ovf[d] = 0; m_hex[d] = '1;
            end
        end else begin
            rise   = start && !m_prev;
            m_prev = start;
            for (int d = 0; d < 2; d++) begin
                if (m_run[d]) begin
                    m_t[d]++;
                    if (m_t[d] == m_n[d] + accw_m[d] + 2) begin
                        s = series(m_n[d], m_mode[d]);
                        o = (s >= (1 << accw_m[d])) || (s > 99999);
                        m_run[d]  = 0;
                        m_done[d] = 1;
                        m_ovf[d]  = o;
                        m_hex[d]  = exp_hex(s, o);
                    end
                end else if (rise) begin
                    m_run[d]  = 1;
                    m_t[d]    = 0;
                    m_done[d] = 0;
                    m_n[d]    = int'(n_in);
                    m_mode[d] = mode;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy0", 64'(busy0), 64'(m_run[0]));
            check("done0", 64'(done0), 64'(m_done[0]));
            check("ovf0",  64'(ovf0),  64'(m_ovf[0]));
            check("hex0",  64'(hex0),  64'(m_hex[0]));
            check("busy1", 64'(busy1), 64'(m_run[1]));
            check("done1", 64'(done1), 64'(m_done[1]));
            check("ovf1",  64'(ovf1),  64'(m_ovf[1]));
            check("hex1",  64'(hex1),  64'(m_hex[1]));
            check("busy_done_excl0", 64'(busy0 & done0), 64'(0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_series(input int n, input bit m, input bit poke, output int edges);
        bit seen = 0;
        @(negedge clk);
        n_in  = 5'(n);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        edges = 0;
        while (!seen && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (poke && edges == 5) begin
                start = 1'b0; n_in = 5'd3; mode = ~m;
            end
            if (poke && edges == 6) start = 1'b1;
            if (done0) seen = 1;
        end
        check("done_timeout", 64'(seen), 64'(1));
        @(negedge clk);
        start = 1'b0;
    endtask

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] D0 = 7'b0000001;
    localparam logic [6:0] D1 = 7'b1001111;
    localparam logic [6:0] D4 = 7'b1001100;
    localparam logic [6:0] D5 = 7'b0100100;
    localparam logic [6:0] D6 = 7'b0100000;
    localparam logic [6:0] DM = 7'b1111110;

    initial begin
        int e;
        int busy_cnt;
        #2 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_done", 64'(done0), 64'(0));
        check("rst_ovf",  64'(ovf0),  64'(0));
        check("rst_hex",  64'(hex0),  64'({B, B, B, B, B}));

        // 1: N=10 sum of i
        run_series(10, 1'b0, 1'b0, e);
        check("t1_edge", 64'(e), 64'(26));
        check("t1_hex",  64'(hex0), 64'({B, B, B, D5, D5}));
        check("t1_ovf",  64'(ovf0), 64'(0));

        // 2: N=31 sum of squares, with start/n_in/mode disturbed mid-run
        run_series(31, 1'b1, 1'b1, e);
        check("t2_edge", 64'(e), 64'(47));
        check("t2_hex",  64'(hex0), 64'({D1, D0, D4, D1, D6}));
        check("t2_ovf",  64'(ovf0), 64'(0));
        // 4: narrow accumulator overflows on the same run
        check("t4_done", 64'(done1), 64'(1));
        check("t4_ovf",  64'(ovf1),  64'(1));
        check("t4_hex",  64'(hex1),  64'({DM, DM, DM, DM, DM}));

        // 3: N=0
        run_series(0, 1'b1, 1'b0, e);
        check("t3_edge", 64'(e), 64'(16));
        check("t3_hex",  64'(hex0), 64'({B, B, B, B, D0}));
        check("t3_ovf",  64'(ovf0), 64'(0));

        // 5: start held high for 100 cycles gives one run
        @(negedge clk);
        n_in = 5'd5; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        busy_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy0) busy_cnt++;
            @(posedge clk);
        end
        #1;
        check("t5_busy_cycles", 64'(busy_cnt), 64'(21));
        check("t5_done", 64'(done0), 64'(1));
        check("t5_hex",  64'(hex0), 64'({B, B, B, D1, D5}));
        @(negedge clk);
        start = 1'b0;

        // 6: reset mid-SUM, then a fresh run
        @(negedge clk);
        n_in = 5'd31; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy0), 64'(0));
        check("t6_rst_done", 64'(done0), 64'(0));
        check("t6_rst_hex",  64'(hex0),  64'({B, B, B, B, B}));
        @(negedge clk);
        rst = 1'b0;
        run_series(4, 1'b0, 1'b0, e);
        check("t6_edge", 64'(e), 64'(20));
        check("t6_hex",  64'(hex0), 64'({B, B, B, D1, D0}));

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
